sb_packet_rx: RTL and testbench
===============================

# sb_packet_rx

System-bus packet receiver that sits directly upstream of every consumer of `definesPkg::Tdata_sb`. It accepts a byte-serial bus stream and hunts for the start code. It assembles the 13-byte frame into one `Tdata_sb` word and checks the checksum and end code. Good packets are presented on a valid/ready output; bad ones are dropped and flagged.

## Interface
Parameters:
- `START_CODE`, default `8'hA5`: frame start byte.
- `END_CODE`, default `8'h5A`: frame end byte.
- `TIMEOUT`, default `16`: maximum idle cycles allowed between bytes inside a frame.

Ports:
- `clk`, in, 1: single clock; all logic on rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `rx_valid`, in, 1: `rx_byte` is valid this cycle.
- `rx_byte`, in, 8: incoming stream byte.
- `rx_ready`, out, 1: receiver accepts a byte this cycle.
- `pkt_valid`, out, 1: `pkt` holds a checked frame.
- `pkt`, out, `Tdata_sb`: assembled frame.
- `pkt_ready`, in, 1: downstream consumes `pkt`.
- `err_checksum`, out, 1: one-cycle pulse when a frame is dropped for a bad checksum.
- `err_framing`, out, 1: one-cycle pulse when a frame is dropped for a bad end code or a timeout.
- `drop_cnt`, out, 8: saturating count of dropped frames.

## Operation
- Frame on wire, 13 bytes: Start, Header.Type, Header.Size, Data[63:56] … Data[7:0] (MSB first), Error, End.
- Error byte = XOR of Type, Size and the 8 data bytes.
- A byte transfers when `rx_valid && rx_ready`.
- FSM states and transitions:
  - IDLE → TYPE on a transferred byte equal to `START_CODE`; any other byte is silently discarded (hunt).
  - TYPE → SIZE → DATA, each on one transferred byte.
  - DATA stays for 8 transferred bytes, using a 3-bit index that wraps 7→0, then → CHK.
  - CHK latches the Error byte, then → END.
  - END: transferred byte equal to `END_CODE` with matching checksum → HOLD.
  - END, bad checksum (regardless of End byte) → IDLE; pulse `err_checksum`.
  - END, good checksum but End byte ≠ `END_CODE` → IDLE; pulse `err_framing`.
  - HOLD: `pkt_valid` high; `pkt_ready` → IDLE.
- `rx_ready` = 0 in HOLD, 1 in all other states (combinational from state).
- Checksum check is priority over the End-code check.
- `pkt` fields:
  - `Start` = `START_CODE`, `End` = `END_CODE`.
  - `Error` = received checksum byte.
  - Header and Data = received bytes.
  - `pkt` is stable throughout HOLD.
- Timeout: in TYPE…END, `TIMEOUT` consecutive cycles without a transfer → IDLE and pulse `err_framing`. The idle counter clears on every transfer.
- Every drop increments `drop_cnt`; it saturates at 255.
- A byte equal to `START_CODE` arriving mid-frame is treated as data, not as a resync.

## Timing
- Reset values:
  - state IDLE, `rx_ready` 1.
  - `pkt_valid` 0, all `pkt` fields 0.
  - `err_*` 0, `drop_cnt` 0, timeout and index counters 0.
- `pkt_valid` rises the cycle after the End byte transfers.
- `err_*` pulses are high for exactly the cycle after the offending byte or timeout expiry.
- `pkt_valid` falls the cycle after `pkt_valid && pkt_ready`.
- `rx_ready` returns high in that same cycle.
- Best-case throughput: 14 cycles per frame (13 bytes plus 1 handshake cycle).
- Timeout fires on the cycle the counter reaches `TIMEOUT`; counter width is `$clog2(TIMEOUT+1)`.
- Reset mid-frame or mid-HOLD discards all partial and held state immediately (asynchronous).

## Structure
- Add to `definesPkg`:
  - `SB_START_CODE`, `SB_END_CODE`, `SB_FRAME_BYTES=13`.
  - `Tsb_type` enum: READ=1, WRITE=2, GRANT=3, RETRY=4, REQ_BUS=5.
  - `Tsb_rx_state` enum.
- The Type byte is passed through unchecked.
- One sub-module, `sb_xor_accum`: 8-bit running XOR with clear and enable, cleared on the IDLE→TYPE transition.

## Test plan
- Good frame: A5 01 08 01 23 45 67 89 AB CD EF 09 5A, `rx_valid` continuous → `pkt_valid` one cycle after 5A with Type=01, Size=08, Data=0123456789ABCDEF, Error=09; `drop_cnt`=0.
- Same frame with checksum byte 0A → no `pkt_valid`, one `err_checksum` pulse, `drop_cnt`=1, FSM back to IDLE.
- Same frame with End byte 5B → one `err_framing` pulse, `drop_cnt`=1.
- Leading garbage 00 FF 5A, then the good frame → garbage ignored with no error pulses; the frame is delivered.
- `rx_valid` dropped for 16 cycles after the 5th byte → `err_framing` pulse; the following good frame is delivered normally.
- HOLD backpressure:
  - Two back-to-back good frames with `pkt_ready` held low for 5 cycles: `rx_ready`=0 and `pkt` stable throughout.
  - After the `pkt_ready` handshake, the second frame is accepted and delivered intact.
- 300 bad frames → `drop_cnt` saturates at 255.
- Assert `rst_n` during DATA → all outputs return to reset values within the same cycle.

Source files
------------

// File: rtl/definesPkg.sv
// Shared system-bus definitions: frame constants, type codes, receiver
// FSM states and the assembled frame word Tdata_sb.
package definesPkg;

  localparam logic [7:0] SB_START_CODE  = 8'hA5;
  localparam logic [7:0] SB_END_CODE    = 8'h5A;
  localparam int         SB_FRAME_BYTES = 13;

  typedef enum logic [7:0] {
    READ    = 8'd1,
    WRITE   = 8'd2,
    GRANT   = 8'd3,
    RETRY   = 8'd4,
    REQ_BUS = 8'd5
  } Tsb_type;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TYPE,
    ST_SIZE,
    ST_DATA,
    ST_CHK,
    ST_END,
    ST_HOLD
  } Tsb_rx_state;

  typedef struct packed {
    logic [7:0] Type;
    logic [7:0] Size;
  } Theader_sb;

  // Field order matches wire order, so the packed word reads like the frame.
  typedef struct packed {
    logic [7:0]  Start;
    Theader_sb   Header;
    logic [63:0] Data;
    logic [7:0]  Error;
    logic [7:0]  End;
  } Tdata_sb;

endpackage

// File: rtl/sb_xor_accum.sv
// Running 8-bit XOR of the frame payload; clear wins over enable.
module sb_xor_accum (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] acc
);

  // Accumulate payload bytes; restart at each new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking so every flop samples pre-edge values.
    if (!rst_n)   acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc ^ din;
  end

endmodule

// File: rtl/sb_packet_rx.sv
// Byte-serial system-bus receiver: hunts for the start code, assembles a
// 13-byte frame into Tdata_sb, checks checksum and end code, and holds good
// frames on a valid/ready output. Bad or stalled frames are dropped and flagged.
module sb_packet_rx
  import definesPkg::*;
#(
  parameter logic [7:0]  START_CODE = SB_START_CODE,
  parameter logic [7:0]  END_CODE   = SB_END_CODE,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       rx_ready,
  output logic       pkt_valid,
  output Tdata_sb    pkt,
  input  logic       pkt_ready,
  output logic       err_checksum,
  output logic       err_framing,
  output logic [7:0] drop_cnt
);

  localparam int unsigned   TW           = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
  localparam int            DATA_BYTES   = SB_FRAME_BYTES - 5;
  localparam logic [2:0]    IDX_LAST     = 3'(DATA_BYTES - 1);

  Tsb_rx_state   state_q, state_d;
  logic [TW-1:0] idle_cnt;
  logic [2:0]    idx;
  logic [7:0]    acc;
  logic          xfer, frame_active, timeout_hit, ck_ok;
  logic          start_hit, drop_ck, drop_fr;

  assign rx_ready     = (state_q != ST_HOLD);
  assign pkt_valid    = (state_q == ST_HOLD);
  assign xfer         = rx_valid && rx_ready;
  assign frame_active = state_q inside {ST_TYPE, ST_SIZE, ST_DATA, ST_CHK, ST_END};
  assign start_hit    = (state_q == ST_IDLE) && xfer && (rx_byte == START_CODE);
  // This is the TIMEOUT-th consecutive cycle without a transfer.
  assign timeout_hit  = frame_active && !xfer && (idle_cnt == TIMEOUT_LAST);
  assign ck_ok        = (acc == pkt.Error);

  sb_xor_accum u_xor (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (start_hit),
    .en   (xfer && (state_q inside {ST_TYPE, ST_SIZE, ST_DATA})),
    .din  (rx_byte),
    .acc  (acc)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state and drop decisions; checksum failure outranks a bad end code.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal (no latch).
    state_d = state_q;
    drop_ck = 1'b0;
    drop_fr = 1'b0;
    if (timeout_hit) begin
      state_d = ST_IDLE;
      drop_fr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: if (start_hit) state_d = ST_TYPE;
        ST_TYPE: if (xfer) state_d = ST_SIZE;
        ST_SIZE: if (xfer) state_d = ST_DATA;
        ST_DATA: if (xfer && idx == IDX_LAST) state_d = ST_CHK;
        ST_CHK:  if (xfer) state_d = ST_END;
        ST_END: begin
          if (xfer) begin
            if (!ck_ok) begin
              state_d = ST_IDLE;
              drop_ck = 1'b1;
            end else if (rx_byte != END_CODE) begin
              state_d = ST_IDLE;
              drop_fr = 1'b1;
            end else begin
              state_d = ST_HOLD;
            end
          end
        end
        ST_HOLD: if (pkt_ready) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Frame assembly, idle timer, error pulses and drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: pkt is a plain register bank, not a RAM, so it can take the async reset.
    if (!rst_n) begin
      pkt          <= '0;
      idx          <= '0;
      idle_cnt     <= '0;
      err_checksum <= 1'b0;
      err_framing  <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      err_checksum <= drop_ck;
      err_framing  <= drop_fr;
      if ((drop_ck || drop_fr) && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;

      if (frame_active && !xfer && !timeout_hit) idle_cnt <= idle_cnt + TW'(1);
      else                                       idle_cnt <= '0;

      // No transfers happen in HOLD, so pkt stays frozen there.
      if (xfer) begin
        case (state_q)
          ST_IDLE: if (start_hit) begin
            pkt.Start <= START_CODE;
            pkt.End   <= END_CODE;
            idx       <= '0;
          end
          ST_TYPE: pkt.Header.Type <= rx_byte;
          ST_SIZE: pkt.Header.Size <= rx_byte;
          ST_DATA: begin
            pkt.Data <= {pkt.Data[55:0], rx_byte};
            idx      <= idx + 3'd1;
          end
          ST_CHK:  pkt.Error <= rx_byte;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sb_packet_rx.sv
// Directed self-checking bench for sb_packet_rx.
module tb_sb_packet_rx;
  import definesPkg::*;

  logic       clk, rst_n, rx_valid, rx_ready, pkt_valid, pkt_ready;
  logic       err_checksum, err_framing, err_seen;
  logic [7:0] rx_byte, drop_cnt;
  Tdata_sb    pkt;
  int         tests, fails;

  // Frames as sent on the wire, first byte in the MSBs; a good frame is also
  // exactly the expected pkt word.
  localparam logic [103:0] GOOD1   = 104'hA5_01_08_0123456789ABCDEF_09_5A;
  localparam logic [103:0] BADCK   = 104'hA5_01_08_0123456789ABCDEF_0A_5A;
  localparam logic [103:0] BADEND  = 104'hA5_01_08_0123456789ABCDEF_09_5B;
  localparam logic [103:0] BADBOTH = 104'hA5_01_08_0123456789ABCDEF_0A_5B;
  localparam logic [103:0] GOOD2   = 104'hA5_03_04_1122334455667788_8F_5A;

  sb_packet_rx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_valid    (rx_valid),
    .rx_byte     (rx_byte),
    .rx_ready    (rx_ready),
    .pkt_valid   (pkt_valid),
    .pkt         (pkt),
    .pkt_ready   (pkt_ready),
    .err_checksum(err_checksum),
    .err_framing (err_framing),
    .drop_cnt    (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [103:0] obs, input logic [103:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    err_seen = err_seen | err_checksum | err_framing;
  endtask

  task automatic send_bytes(input logic [103:0] f, input int n);
    for (int i = 12; i > 12 - n; i--) send(f[i*8 +: 8]);
  endtask

  task automatic do_reset();
    rx_valid  = 1'b0;
    rx_byte   = 8'h00;
    pkt_ready = 1'b0;
    rst_n     = 1'b0;
    #4;
    rst_n    = 1'b1;
    err_seen = 1'b0;
    tick();
  endtask

  task automatic handshake();
    pkt_ready = 1'b1;
    tick();
    pkt_ready = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0; err_seen = 1'b0;
    rx_valid = 1'b0; rx_byte = 8'h00; pkt_ready = 1'b0; rst_n = 1'b0;
    tick();

    // Reset values while reset is held.
    check("rst_rx_ready",  rx_ready,     1);
    check("rst_pkt_valid", pkt_valid,    0);
    check("rst_pkt",       pkt,          0);
    check("rst_errs",      {err_checksum, err_framing}, 0);
    check("rst_drop",      drop_cnt,     0);
    do_reset();

    // Good frame, continuous valid.
    send_bytes(GOOD1, 12);
    check("good_not_yet", pkt_valid, 0);
    send_bytes(GOOD1 << 96, 1);
    rx_valid = 1'b0;
    check("good_valid",    pkt_valid, 1);
    check("good_rx_ready", rx_ready,  0);
    check("good_pkt",      pkt,       GOOD1);
    check("good_drop",     drop_cnt,  0);
    check("good_no_err",   err_seen,  0);
    handshake();
    check("good_valid_fall", pkt_valid, 0);
    check("good_ready_back", rx_ready,  1);

    // Bad checksum.
    do_reset();
    send_bytes(BADCK, 13);
    rx_valid = 1'b0;
    check("ck_pulse",   err_checksum, 1);
    check("ck_no_fr",   err_framing,  0);
    check("ck_novalid", pkt_valid,    0);
    check("ck_drop",    drop_cnt,     1);
    tick();
    check("ck_pulse_end", err_checksum, 0);
    check("ck_idle",      rx_ready,     1);

    // Bad end code.
    do_reset();
    send_bytes(BADEND, 13);
    rx_valid = 1'b0;
    check("end_pulse", err_framing,  1);
    check("end_no_ck", err_checksum, 0);
    check("end_drop",  drop_cnt,     1);
    tick();
    check("end_pulse_end", err_framing, 0);

    // Bad checksum and bad end: checksum has priority.
    do_reset();
    send_bytes(BADBOTH, 13);
    rx_valid = 1'b0;
    check("both_ck", {err_checksum, err_framing}, 2'b10);

    // Leading garbage then a good frame.
    do_reset();
    send(8'h00); send(8'hFF); send(8'h5A);
    send_bytes(GOOD1, 13);
    rx_valid = 1'b0;
    check("hunt_no_err", err_seen,  0);
    check("hunt_valid",  pkt_valid, 1);
    check("hunt_pkt",    pkt,       GOOD1);
    check("hunt_drop",   drop_cnt,  0);
    handshake();

    // Timeout: stall 16 cycles after the 5th byte.
    do_reset();
    send_bytes(GOOD1, 5);
    rx_valid = 1'b0;
    repeat (15) tick();
    check("to_not_yet", err_framing, 0);
    tick();
    check("to_pulse", err_framing, 1);
    check("to_drop",  drop_cnt,    1);
    send_bytes(GOOD1, 13);
    rx_valid = 1'b0;
    check("to_next_valid", pkt_valid, 1);
    check("to_next_pkt",   pkt,       GOOD1);
    handshake();

    // HOLD backpressure with a second frame waiting.
    do_reset();
    send_bytes(GOOD1, 13);
    rx_byte = GOOD2[103:96];
    for (int i = 0; i < 5; i++) begin
      check("bp_rx_ready", rx_ready,  0);
      check("bp_valid",    pkt_valid, 1);
      check("bp_pkt",      pkt,       GOOD1);
      tick();
    end
    handshake();
    check("bp_released", {pkt_valid, rx_ready}, 2'b01);
    send_bytes(GOOD2, 13);
    rx_valid = 1'b0;
    check("bp2_valid", pkt_valid, 1);
    check("bp2_pkt",   pkt,       GOOD2);
    rst_n = 1'b0;
    #1;
    check("hold_rst", {pkt_valid, rx_ready}, 2'b01);
    #2;
    rst_n = 1'b1;
    tick();

    // Drop counter saturation.
    do_reset();
    for (int i = 0; i < 254; i++) send_bytes(BADCK, 13);
    check("sat_254", drop_cnt, 8'hFE);
    for (int i = 0; i < 46; i++) send_bytes(BADCK, 13);
    rx_valid = 1'b0;
    check("sat_300", drop_cnt, 8'hFF);

    // Asynchronous reset during DATA.
    do_reset();
    send_bytes(GOOD1, 13);
    handshake();
    send_bytes(BADCK, 13);
    send_bytes(GOOD1, 6);
    rst_n = 1'b0;
    #1;
    check("mid_rst_pkt",   pkt,       0);
    check("mid_rst_drop",  drop_cnt,  0);
    check("mid_rst_flags", {pkt_valid, rx_ready, err_checksum, err_framing}, 4'b0100);
    rx_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    send_bytes(GOOD2, 13);
    rx_valid = 1'b0;
    check("post_rst_pkt", pkt, GOOD2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
